// File: rtl/local_branch_predictor.sv
// local_branch_predictor: two-level local predictor, per-PC history (BHT) indexing shared saturating counters (PHT).
// Define LOCAL_PRED_STATS_EN to build the resolved-branch / mispredict counters.
module local_branch_predictor #(
  parameter int ADDR_IDX_BITS = 10,
  parameter int HIST_BITS = 10,
  parameter int CTR_BITS = 2,
  parameter int CTR_INIT = 1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        Pred_valid,
  input  logic [31:0] Pred_instr,
  input  logic [31:0] Pred_addr,
  output logic        Pred_out_valid,
  output logic        Pred_is_branch,
  output logic        Taken,
  output logic        Ready,
  input  logic        Upd_valid,
  input  logic [31:0] Upd_addr,
  input  logic        Upd_taken,
  input  logic        Upd_pred,
  output logic [31:0] Stat_branches,
  output logic [31:0] Stat_mispredicts
);
  localparam int BHT_N = 1 << ADDR_IDX_BITS;
  localparam int PHT_N = 1 << HIST_BITS;
  localparam int SW = ADDR_IDX_BITS > HIST_BITS ? ADDR_IDX_BITS : HIST_BITS;
  localparam logic [SW-1:0] LAST = '1;

  typedef enum logic {INIT, RUN} state_t;
  state_t state;
  logic [SW-1:0] idx;

  logic [HIST_BITS-1:0] bht [BHT_N];
  logic [CTR_BITS-1:0] pht [PHT_N];

  logic [ADDR_IDX_BITS-1:0] p_idx, u_idx;
  logic [HIST_BITS-1:0] p_h, u_h;
  logic [CTR_BITS-1:0] u_c, u_next;
  logic is_br, unused;

  assign p_idx = Pred_addr[ADDR_IDX_BITS+1:2];
  assign u_idx = Upd_addr[ADDR_IDX_BITS+1:2];
  assign p_h = bht[p_idx];
  assign u_h = bht[u_idx];
  assign u_c = pht[u_h];
  assign u_next = Upd_taken ? (&u_c ? u_c : u_c + 1'b1) : (|u_c ? u_c - 1'b1 : u_c);
  // REGIMM branches are the rt values with rt[3:1] == 0; opcodes 4..7 are BEQ/BNE/BLEZ/BGTZ
  assign is_br = (Pred_instr[31:26] == 6'b000001 && Pred_instr[19:17] == 3'b000) ||
                 Pred_instr[31:28] == 4'b0001 && Pred_instr[27:26] != 2'b11 ? 1'b1 :
                 Pred_instr[31:26] == 6'b000111;
  assign unused = ^{Pred_instr[25:20], Pred_instr[16:0], Pred_addr[31:ADDR_IDX_BITS+2], Pred_addr[1:0],
                    Upd_addr[31:ADDR_IDX_BITS+2], Upd_addr[1:0], Upd_pred};

  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      state <= INIT;
      idx <= '0;
      Ready <= 1'b0;
      Pred_out_valid <= 1'b0;
      Pred_is_branch <= 1'b0;
      Taken <= 1'b0;
    end else begin
      Ready <= state == RUN;
      if (state == INIT) begin
        idx <= idx + 1'b1;
        if (idx == LAST) state <= RUN;
      end
      Pred_out_valid <= Ready & Pred_valid;
      Pred_is_branch <= Ready & Pred_valid & is_br;
      Taken <= Ready & Pred_valid & is_br & pht[p_h][CTR_BITS-1];
    end

  // Tables carry no reset; the INIT sweep clears them after every RESET
  always_ff @(posedge CLK)
    if (state == INIT) begin
      if (32'(idx) < BHT_N) bht[idx[ADDR_IDX_BITS-1:0]] <= '0;
      if (32'(idx) < PHT_N) pht[idx[HIST_BITS-1:0]] <= CTR_BITS'(CTR_INIT);
    end else if (Ready && Upd_valid) begin
      pht[u_h] <= u_next;
      bht[u_idx] <= {u_h[HIST_BITS-2:0], Upd_taken};
    end

`ifdef LOCAL_PRED_STATS_EN
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      Stat_branches <= '0;
      Stat_mispredicts <= '0;
    end else if (Ready && Upd_valid) begin
      if (~&Stat_branches) Stat_branches <= Stat_branches + 1'b1;
      if (Upd_pred != Upd_taken && ~&Stat_mispredicts) Stat_mispredicts <= Stat_mispredicts + 1'b1;
    end
`else
  assign Stat_branches = '0;
  assign Stat_mispredicts = '0;
`endif
endmodule

// File: tb/tb_local_branch_predictor.sv
// tb_local_branch_predictor: scoreboard bench against a behavioural model of the local predictor.
module tb_local_branch_predictor;
`ifdef LOCAL_PRED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic pred_valid = 1'b0, upd_valid = 1'b0, upd_taken = 1'b0, upd_pred = 1'b0;
  logic [31:0] pred_instr = '0, pred_addr = '0, upd_addr = '0;
  logic pred_out_valid, pred_is_branch, taken, ready;
  logic [31:0] stat_branches, stat_mispredicts;

  local_branch_predictor dut (
    .CLK(clk), .RESET(rst),
    .Pred_valid(pred_valid), .Pred_instr(pred_instr), .Pred_addr(pred_addr),
    .Pred_out_valid(pred_out_valid), .Pred_is_branch(pred_is_branch), .Taken(taken), .Ready(ready),
    .Upd_valid(upd_valid), .Upd_addr(upd_addr), .Upd_taken(upd_taken), .Upd_pred(upd_pred),
    .Stat_branches(stat_branches), .Stat_mispredicts(stat_mispredicts)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  bit [9:0] m_bht [1024];
  bit [1:0] m_pht [1024];
  int m_br = 0, m_mp = 0;
  logic [1:0] q [$];
  logic obs;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit is_branch(input logic [31:0] i);
    case (i[31:26])
      6'h04, 6'h05, 6'h06, 6'h07: return 1'b1;
      6'h01: return i[20:16] inside {5'h00, 5'h10, 5'h01, 5'h11};
      default: return 1'b0;
    endcase
  endfunction

  function automatic void m_clear();
    for (int i = 0; i < 1024; i++) begin
      m_bht[i] = '0;
      m_pht[i] = 2'd1;
    end
    m_br = 0;
    m_mp = 0;
  endfunction

  // One cycle: drive, model (prediction before update), then compare after the edge
  task automatic tick(input logic pv, input logic [31:0] instr, input logic [31:0] paddr,
                      input logic uv, input logic [31:0] uaddr, input logic ut, input logic up);
    bit [9:0] h;
    bit b;
    logic [1:0] e;
    pred_valid = pv; pred_instr = instr; pred_addr = paddr;
    upd_valid = uv; upd_addr = uaddr; upd_taken = ut; upd_pred = up;
    if (pv) begin
      b = is_branch(instr);
      h = m_bht[paddr[11:2]];
      q.push_back({b, b && m_pht[h] >= 2'd2});
    end
    if (uv) begin
      h = m_bht[uaddr[11:2]];
      if (ut && m_pht[h] != 2'd3) m_pht[h]++;
      if (!ut && m_pht[h] != 2'd0) m_pht[h]--;
      m_bht[uaddr[11:2]] = {h[8:0], ut};
      m_br++;
      if (up != ut) m_mp++;
    end
    @(posedge clk); #1;
    pred_valid = 1'b0;
    upd_valid = 1'b0;
    chk("out_valid", pred_out_valid, pv);
    if (pv) begin
      e = q.pop_front();
      chk("is_branch", pred_is_branch, e[1]);
      chk("taken", taken, e[0]);
    end
    obs = taken;
  endtask

  task automatic do_reset();
    int n;
    bit leak;
    rst = 1'b1;
    #1;
    chk("rst_ready", ready, 0);
    chk("rst_pov", pred_out_valid, 0);
    chk("rst_stat_br", stat_branches, 0);
    chk("rst_stat_mp", stat_mispredicts, 0);
    q.delete();
    m_clear();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    // Requests during INIT must be ignored
    pred_valid = 1'b1; pred_instr = 32'h1000_0000; pred_addr = 32'h400;
    upd_valid = 1'b1; upd_addr = 32'h400; upd_taken = 1'b1; upd_pred = 1'b0;
    n = 0;
    leak = 1'b0;
    while (!ready && n < 2000) begin
      @(posedge clk); #1;
      n++;
      if (pred_out_valid) leak = 1'b1;
    end
    pred_valid = 1'b0;
    upd_valid = 1'b0;
    chk("ready_edges", n, 1025);
    chk("init_pov", {31'd0, leak}, 0);
    chk("init_stat_br", stat_branches, 0);
  endtask

  localparam logic [31:0] BEQ = 32'h1000_0000;
  logic [31:0] instrs [12] = '{32'h1000_0000, 32'h1400_0000, 32'h1800_0000, 32'h1C00_0000,
                               32'h0400_0000, 32'h0401_0000, 32'h0410_0000, 32'h0411_0000,
                               32'h8C01_0000, 32'h0402_0000, 32'h0800_0000, 32'h0412_0000};
  logic [31:0] addrs [6] = '{32'h0, 32'h4, 32'h400, 32'h1000, 32'h1004, 32'h8000_0400};

  initial begin
    logic pat;
    logic [31:0] mp_mark;
    do_reset();
    tick(1, BEQ, 32'h400, 0, 0, 0, 0);
    chk("first_beq_taken", obs, 0);
    foreach (instrs[i]) tick(1, instrs[i], 32'h400, 0, 0, 0, 0);
    // Saturate toward taken, then toward not-taken
    repeat (13) tick(0, 0, 0, 1, 32'h400, 1, 0);
    tick(1, BEQ, 32'h400, 0, 0, 0, 0);
    chk("sat_taken", obs, 1);
    repeat (14) tick(0, 0, 0, 1, 32'h400, 0, 1);
    tick(1, BEQ, 32'h400, 0, 0, 0, 0);
    chk("sat_not_taken", obs, 0);
    // Loop pattern T,T,T,N
    mp_mark = 0;
    for (int it = 0; it < 20; it++) begin
      if (it == 15) mp_mark = stat_mispredicts;
      for (int k = 0; k < 4; k++) begin
        pat = k != 3;
        tick(1, BEQ, 32'h1000, 0, 0, 0, 0);
        if (it >= 15) chk("loop_pred", obs, pat);
        tick(0, 0, 0, 1, 32'h1000, pat, obs);
      end
    end
    chk("loop_stat_mp", stat_mispredicts, mp_mark);
    chk("stat_br", stat_branches, STATS ? m_br : 0);
    chk("stat_mp", stat_mispredicts, STATS ? m_mp : 0);
    // Mid-run reset after training strongly taken
    repeat (13) tick(0, 0, 0, 1, 32'h400, 1, 0);
    tick(1, BEQ, 32'h400, 0, 0, 0, 0);
    chk("pre_reset_taken", obs, 1);
    pred_valid = 1'b1; pred_instr = BEQ; pred_addr = 32'h400;
    @(posedge clk); #2;
    do_reset();
    tick(1, BEQ, 32'h400, 0, 0, 0, 0);
    chk("post_reset_taken", obs, 0);
    chk("post_reset_stat", stat_branches, 0);
    // Same-cycle predict and update: prediction sees pre-update state
    tick(1, BEQ, 32'h400, 1, 32'h400, 1, 0);
    chk("simul_taken", obs, 0);
    tick(1, BEQ, 32'h400, 0, 0, 0, 0);
    tick(1, BEQ, 32'h800, 0, 0, 0, 0);
    chk("simul_visible", obs, 1);
    // Random mix
    for (int i = 0; i < 300; i++)
      tick($urandom_range(0, 1), instrs[$urandom_range(0, 11)], addrs[$urandom_range(0, 5)],
           $urandom_range(0, 1), addrs[$urandom_range(0, 5)], $urandom_range(0, 1), $urandom_range(0, 1));
    chk("final_stat_br", stat_branches, STATS ? m_br : 0);
    chk("final_stat_mp", stat_mispredicts, STATS ? m_mp : 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
